gpif_cmd_sequencer: RTL and testbench
=====================================

Name: gpif_cmd_sequencer

Overview:
- Pops 32-bit command words from the GPIF ingress FIFO and decodes framed commands of the form sync word, command word, optional data word.
- Executes each command as a single AXI4-Lite read or write toward system memory and pushes one result word per command into the egress FIFO.
- Sits between the GPIF ingress FIFO read port and the AXI interconnect; it is the sole master on that AXI port.

Parameters:
- SYNC_WORD, 32'hABABABAB, frame start marker.
- BASE_ADDR, 32'h0000_0000, byte address added to (word address << 2).
- ERR_CNT_W, 8, width of the error counter; the counter saturates.

Ports:
- aclk  in  1  system clock; every flop samples on its rising edge.
- areset  in  1  asynchronous active-high reset.
- cmd_dout  in  32  ingress FIFO read data; valid 1 cycle after cmd_rd_en (standard FIFO, not FWFT).
- cmd_empty  in  1  ingress FIFO empty flag.
- cmd_rd_en  out  1  ingress FIFO pop strobe.
- rsp_din  out  32  egress FIFO write data.
- rsp_wr_en  out  1  egress FIFO push strobe.
- rsp_full  in  1  egress FIFO full flag.
- m_axi_awaddr/awvalid/awready  out32/out1/in1  AXI4-Lite write address channel.
- m_axi_wdata/wstrb/wvalid/wready  out32/out4/out1/in1  AXI4-Lite write data channel; wstrb is fixed at 4'hF.
- m_axi_bresp/bvalid/bready  in2/in1/out1  AXI4-Lite write response channel.
- m_axi_araddr/arvalid/arready  out32/out1/in1  AXI4-Lite read address channel.
- m_axi_rdata/rresp/rvalid/rready  in32/in2/in1/out1  AXI4-Lite read data channel.
- busy  out  1  high in every state other than HUNT_POP.
- resp_err  out  1  sticky; set when bresp or rresp is non-zero; cleared only by reset.
- err_count  out  ERR_CNT_W  count of bad-opcode frames; saturates at all-ones.

Behaviour:
- Reset (asynchronous, active-high): state HUNT_POP; all valid/ready/strobe outputs 0; all address and data outputs 0; wstrb 4'hF; busy, resp_err and err_count 0.
- Reset during an in-flight AXI transaction drops valid/ready immediately. This is legal only under system-wide reset.
- Pop primitive: in a *_POP state, if !cmd_empty, pulse cmd_rd_en for 1 cycle and go to the matching *_CHK state. In *_CHK, sample cmd_dout. The minimum cost is 2 cycles per word. cmd_rd_en is never high on 2 consecutive cycles.
- HUNT_CHK: if word == SYNC_WORD go to CMD_POP, else go to HUNT_POP. Non-sync words are silently discarded.
- CMD_CHK: latch opcode = word[31:28] and addr = BASE_ADDR + {word[27:0],2'b00}, truncated mod 2^32.
  - opcode 4'h1 (read) -> AR.
  - opcode 4'h2 (write) -> DATA_POP.
  - any other opcode -> err_count++ and go to HUNT_POP.
- DATA_CHK: latch wdata, then go to AW_W.
- AR: arvalid=1 with araddr=addr, held until arready; then R.
- R: rready=1; on rvalid, latch rdata, OR (rresp!=0) into resp_err, then RSP_PUSH.
- AW_W: awvalid and wvalid are asserted together in the same cycle.
  - Each drops independently on its own handshake.
  - Handshakes may occur in the same cycle or in either order.
  - When both channels have completed, go to B.
- B: bready=1; on bvalid, response word = {30'b0,bresp}, OR (bresp!=0) into resp_err, then RSP_PUSH.
- RSP_PUSH: wait while rsp_full. When !rsp_full, pulse rsp_wr_en for 1 cycle with rsp_din held, then go to HUNT_POP.
- Exactly one response word per valid frame. Bad-opcode frames produce no response.
- Outstanding transactions: at most 1. There is no timeout; a hung slave stalls the block, visible as busy stuck at 1.
- Ingress FIFO empty mid-frame: the block waits in the *_POP state indefinitely. Partial frames are not aborted.
- A sync word received where a command or data word is expected is treated as that command or data word. There is no resync.

Decomposition:
- Package gpif_pkg holds:
  - state enum: HUNT_POP, HUNT_CHK, CMD_POP, CMD_CHK, DATA_POP, DATA_CHK, AR, R, AW_W, B, RSP_PUSH;
  - opcode constants OP_READ=4'h1 and OP_WRITE=4'h2;
  - AXI response constants OKAY=2'b00 and SLVERR=2'b10.
- There is no sub-module; the pop primitive is folded into the FSM.
- An optional helper gpif_axil_master_if is not required.

Test Plan:
- Push AB..AB, 20000004, DEADBEEF -> AW addr 0x10 with wdata DEADBEEF, wstrb F. Then push AB..AB, 10000004 -> AR addr 0x10; rsp_din sequence 00000000 then DEADBEEF; resp_err 0.
- Push AB..AB, 10000001 with the VIP memory default set to FFFFFFFF -> araddr 0x4, rsp_din FFFFFFFF, exactly 1 rsp_wr_en pulse.
- Push 12345678, 0, AB..AB, 10000000 -> the first 2 words are discarded, 1 read at 0x0, 1 response; err_count 0.
- Push AB..AB, 70000000 -> no AXI valid asserted, err_count 1, busy returns to 0. Follow with a valid read -> it completes normally.
- Hold rsp_full=1 during a read -> the FSM stays in RSP_PUSH with rsp_wr_en 0. Release rsp_full -> exactly 1 push with the correct data.
- VIP delays wready 5 cycles after awready, and separately returns SLVERR on a read -> write completes only after both handshakes; resp_err=1 and stays at 1 until areset.

Source files
------------

// File: rtl/gpif_pkg.sv
// Shared types and constants for the GPIF command sequencer.
`timescale 1ns/1ps
package gpif_pkg;

  typedef enum logic [3:0] {
    HUNT_POP,
    HUNT_CHK,
    CMD_POP,
    CMD_CHK,
    DATA_POP,
    DATA_CHK,
    AR,
    R,
    AW_W,
    B,
    RSP_PUSH
  } gpif_state_e;

  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/gpif_cmd_sequencer.sv
// Decodes sync/command/data frames from the GPIF ingress FIFO, runs one AXI4-Lite
// read or write per frame and pushes one result word per valid frame to the egress FIFO.
`timescale 1ns/1ps
module gpif_cmd_sequencer
  import gpif_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD = 32'hABAB_ABAB,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [31:0]          cmd_dout,
  input  logic                 cmd_empty,
  output logic                 cmd_rd_en,
  output logic [31:0]          rsp_din,
  output logic                 rsp_wr_en,
  input  logic                 rsp_full,
  output logic [31:0]          m_axi_awaddr,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  output logic [31:0]          m_axi_wdata,
  output logic [3:0]           m_axi_wstrb,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  input  logic [1:0]           m_axi_bresp,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready,
  output logic [31:0]          m_axi_araddr,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic [31:0]          m_axi_rdata,
  input  logic [1:0]           m_axi_rresp,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready,
  output logic                 busy,
  output logic                 resp_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [3:0]           dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid is never withdrawn before that edge and never depends on ready.

  gpif_state_e          state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rsp_q, rsp_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic                 resp_err_q, resp_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 pop_req;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= HUNT_POP;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      resp_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_q      <= rsp_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      resp_err_q <= resp_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_d      = rsp_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    resp_err_d = resp_err_q;
    err_cnt_d  = err_cnt_q;
    pop_req    = 1'b0;
    case (state_q)
      HUNT_POP: if (!cmd_empty) begin
        pop_req = 1'b1;
        state_d = HUNT_CHK;
      end
      HUNT_CHK: state_d = (cmd_dout == SYNC_WORD) ? CMD_POP : HUNT_POP;
      CMD_POP: if (!cmd_empty) begin
        pop_req = 1'b1;
        state_d = CMD_CHK;
      end
      CMD_CHK: begin
        addr_d = BASE_ADDR + {cmd_dout[27:0], 2'b00};
        case (cmd_dout[31:28])
          OP_READ:  state_d = AR;
          OP_WRITE: state_d = DATA_POP;
          default: begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            state_d = HUNT_POP;
          end
        endcase
      end
      DATA_POP: if (!cmd_empty) begin
        pop_req = 1'b1;
        state_d = DATA_CHK;
      end
      DATA_CHK: begin
        wdata_d   = cmd_dout;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = AW_W;
      end
      AR: if (m_axi_arready) state_d = R;
      R: if (m_axi_rvalid) begin
        rsp_d      = m_axi_rdata;
        resp_err_d = resp_err_q | (m_axi_rresp != OKAY);
        state_d    = RSP_PUSH;
      end
      AW_W: begin
        // Address and data channels complete independently, in any order.
        aw_done_d = aw_done_q | m_axi_awready;
        w_done_d  = w_done_q | m_axi_wready;
        if (aw_done_d && w_done_d) state_d = B;
      end
      B: if (m_axi_bvalid) begin
        rsp_d      = {30'b0, m_axi_bresp};
        resp_err_d = resp_err_q | (m_axi_bresp != OKAY);
        state_d    = RSP_PUSH;
      end
      RSP_PUSH: if (!rsp_full) state_d = HUNT_POP;
      default: state_d = HUNT_POP;
    endcase
  end

  // Gating with reset keeps the pop strobe low while reset holds the FSM in HUNT_POP.
  assign cmd_rd_en     = pop_req & ~areset;
  assign rsp_wr_en     = (state_q == RSP_PUSH) & ~rsp_full;
  assign rsp_din       = rsp_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = (state_q == AW_W) & ~aw_done_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = (state_q == AW_W) & ~w_done_q;
  assign m_axi_bready  = (state_q == B);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = (state_q == AR);
  assign m_axi_rready  = (state_q == R);
  assign busy          = (state_q != HUNT_POP);
  assign resp_err      = resp_err_q;
  assign err_count     = err_cnt_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_gpif_cmd_sequencer.sv
// Self-checking bench for gpif_cmd_sequencer: FIFO and AXI4-Lite slave models plus a
// frame-level reference model feeding expected queues.
`timescale 1ns/1ps
module tb_gpif_cmd_sequencer;
  import gpif_pkg::*;

  localparam logic [31:0] SYNC = 32'hABAB_ABAB;
  localparam int ECW = 8;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [31:0]    cmd_dout;
  logic           cmd_empty, cmd_rd_en;
  logic [31:0]    rsp_din;
  logic           rsp_wr_en, rsp_full;
  logic [31:0]    m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic           m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]     m_axi_wstrb;
  logic [1:0]     m_axi_bresp, m_axi_rresp;
  logic           m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic           m_axi_rvalid, m_axi_rready;
  logic           busy, resp_err;
  logic [ECW-1:0] err_count;
  logic [3:0]     dbg_state;

  gpif_cmd_sequencer dut (
    .aclk(aclk), .areset(areset),
    .cmd_dout(cmd_dout), .cmd_empty(cmd_empty), .cmd_rd_en(cmd_rd_en),
    .rsp_din(rsp_din), .rsp_wr_en(rsp_wr_en), .rsp_full(rsp_full),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .busy(busy), .resp_err(resp_err), .err_count(err_count), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];     // expected response words, in order
  logic [64:0] exp_ax_q[$];  // expected AXI transactions {is_write, addr, wdata}
  logic [31:0] fifo_q[$];    // ingress FIFO contents
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] vip_mem[logic [31:0]];
  logic [31:0] mem_default = 32'h0;
  bit exp_err;
  int exp_errcnt;
  int n_checks, n_fail, n_push;
  bit w_delay_mode, rand_full;

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] next_ax();
    if (exp_ax_q.size() == 0) return {65{1'b1}};
    return exp_ax_q.pop_front();
  endfunction

  function automatic logic [32:0] next_rsp();
    if (exp_q.size() == 0) return {1'b1, 32'h0};
    return {1'b0, exp_q.pop_front()};
  endfunction

  // Slave error map: reads with addr[29] set and writes with addr[29:28]==2'b11 get SLVERR.
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : mem_default;
  endfunction

  function automatic logic [31:0] vip_rd(input logic [31:0] a);
    return vip_mem.exists(a) ? vip_mem[a] : mem_default;
  endfunction

  // Frame-level reference: walk the word stream, find frames, derive transactions.
  task automatic model_stream(input logic [31:0] w[$]);
    int i = 0;
    logic [31:0] a;
    while (i < w.size()) begin
      if (w[i] != SYNC) begin
        i++;
      end else if (i + 1 >= w.size()) begin
        break;
      end else begin
        a = BASE_OFFSET(w[i+1]);
        if (w[i+1][31:28] == 4'h1) begin
          exp_ax_q.push_back({1'b0, a, 32'h0});
          exp_q.push_back(model_rd(a));
          if (a[29]) exp_err = 1'b1;
          i += 2;
        end else if (w[i+1][31:28] == 4'h2) begin
          if (i + 2 >= w.size()) break;
          exp_ax_q.push_back({1'b1, a, w[i+2]});
          if (a[29:28] == 2'b11) begin
            exp_q.push_back(32'h2);
            exp_err = 1'b1;
          end else begin
            model_mem[a] = w[i+2];
            exp_q.push_back(32'h0);
          end
          i += 3;
        end else begin
          if (exp_errcnt < (1 << ECW) - 1) exp_errcnt++;
          i += 2;
        end
      end
    end
  endtask

  function automatic logic [31:0] BASE_OFFSET(input logic [31:0] cmd);
    return 32'h0 + (cmd[27:0] * 4);
  endfunction

  // ---------------- FIFO and AXI slave models (drive at negedge, sample at negedge+1) ----
  initial begin : vip_blk
    bit pend, prev_rd;
    bit arv_l, awv_l, wv_l, rr_l, br_l;
    logic [31:0] ara_l, awa_l, wd_l;
    logic [3:0] ws_l;
    bit ar_hs, aw_hs, w_hs, r_hs, b_hs;
    bit r_busy, b_busy, aw_got, w_got;
    int r_wait, b_wait, w_cnt;
    logic [31:0] aw_c, wd_c;
    cmd_dout = '0; cmd_empty = 1'b1;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_bvalid = 0; m_axi_bresp = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        pend = 0; prev_rd = 0;
        arv_l = 0; awv_l = 0; wv_l = 0; rr_l = 0; br_l = 0;
        r_busy = 0; b_busy = 0; aw_got = 0; w_got = 0; w_cnt = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_rvalid = 0; m_axi_bvalid = 0;
        cmd_empty = (fifo_q.size() == 0);
      end else begin
        if (pend) begin
          cmd_dout = fifo_q.pop_front();
          pend = 0;
        end
        cmd_empty = (fifo_q.size() == 0);
        ar_hs = m_axi_arready && arv_l;
        aw_hs = m_axi_awready && awv_l;
        w_hs  = m_axi_wready && wv_l;
        r_hs  = m_axi_rvalid && rr_l;
        b_hs  = m_axi_bvalid && br_l;
        // read slave
        if (r_hs) begin
          m_axi_rvalid = 0;
          r_busy = 0;
        end
        if (ar_hs) begin
          check_eq("ar_txn", {1'b0, ara_l, 32'h0}, next_ax());
          m_axi_rdata = vip_rd(ara_l);
          m_axi_rresp = ara_l[29] ? SLVERR : OKAY;
          r_busy = 1;
          r_wait = $urandom_range(0, 3);
        end
        if (r_busy && !m_axi_rvalid) begin
          if (r_wait == 0) m_axi_rvalid = 1;
          else r_wait--;
        end
        m_axi_arready = !r_busy && ($urandom_range(0, 1) == 1);
        // write slave
        if (b_hs) begin
          m_axi_bvalid = 0;
          b_busy = 0; aw_got = 0; w_got = 0;
        end
        if (aw_hs) begin
          aw_got = 1; aw_c = awa_l; w_cnt = 0;
        end else if (aw_got && !w_got) begin
          w_cnt++;
        end
        if (w_hs) begin
          w_got = 1; wd_c = wd_l;
          check_eq("wstrb", ws_l, 4'hF);
        end
        if (aw_got && w_got && !b_busy) begin
          check_eq("aw_w_txn", {1'b1, aw_c, wd_c}, next_ax());
          if (aw_c[29:28] == 2'b11) begin
            m_axi_bresp = SLVERR;
          end else begin
            vip_mem[aw_c] = wd_c;
            m_axi_bresp = OKAY;
          end
          b_busy = 1;
          b_wait = $urandom_range(0, 3);
        end
        if (b_busy && !m_axi_bvalid) begin
          if (b_wait == 0) m_axi_bvalid = 1;
          else b_wait--;
        end
        m_axi_awready = !aw_got && ($urandom_range(0, 1) == 1);
        m_axi_wready  = !w_got && (w_delay_mode ? (aw_got && w_cnt >= 5)
                                                : ($urandom_range(0, 1) == 1));
        #1;
        if (cmd_rd_en) begin
          check_eq("rd_en_gap", prev_rd, 0);
          pend = 1;
        end
        prev_rd = cmd_rd_en;
        if (rsp_wr_en) begin
          n_push++;
          check_eq("rsp_din", {1'b0, rsp_din}, next_rsp());
        end
        if (m_axi_bready) check_eq("bready_early", aw_got && w_got, 1);
        arv_l = m_axi_arvalid; ara_l = m_axi_araddr;
        awv_l = m_axi_awvalid; awa_l = m_axi_awaddr;
        wv_l  = m_axi_wvalid;  wd_l  = m_axi_wdata; ws_l = m_axi_wstrb;
        rr_l  = m_axi_rready;  br_l  = m_axi_bready;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] w[$], input bit gaps);
    model_stream(w);
    foreach (w[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge aclk);
      fifo_q.push_back(w[i]);
    end
  endtask

  task automatic send_n(input int n, input logic [31:0] w0, input logic [31:0] w1 = 0,
                        input logic [31:0] w2 = 0, input logic [31:0] w3 = 0);
    logic [31:0] q[$];
    if (n > 0) q.push_back(w0);
    if (n > 1) q.push_back(w1);
    if (n > 2) q.push_back(w2);
    if (n > 3) q.push_back(w3);
    send(q, 1'b0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    bit idle;
    do begin
      @(negedge aclk);
      if (rand_full) rsp_full = ($urandom_range(0, 3) == 0);
      #2;
      n++;
      idle = (fifo_q.size() == 0) && !busy && (exp_q.size() == 0) && (exp_ax_q.size() == 0);
    end while (!idle && n < budget);
    check_eq({tag, "_idle"}, idle, 1);
    @(negedge aclk);
    rsp_full = 0;
  endtask

  task automatic pulse_reset();
    @(negedge aclk);
    areset = 1;
    repeat (2) @(negedge aclk);
    areset = 0;
    exp_err = 0;
    exp_errcnt = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin : main_blk
    int p, n;
    logic [31:0] q[$];
    logic [31:0] cmd;
    rsp_full = 0;
    n_checks = 0; n_fail = 0; n_push = 0;
    exp_err = 0; exp_errcnt = 0;
    w_delay_mode = 0; rand_full = 0;

    // reset values, with the ingress FIFO non-empty while reset is held
    fifo_q.push_back(SYNC);
    repeat (3) @(negedge aclk);
    #2;
    check_eq("rst_strobes", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready,
                             m_axi_bready, rsp_wr_en, cmd_rd_en, busy, resp_err}, 0);
    check_eq("rst_addr", {m_axi_awaddr, m_axi_araddr}, 0);
    check_eq("rst_data", {m_axi_wdata, rsp_din}, 0);
    check_eq("rst_wstrb", m_axi_wstrb, 4'hF);
    check_eq("rst_err_count", err_count, 0);
    check_eq("rst_state", dbg_state, 4'(HUNT_POP));
    fifo_q.delete();
    @(negedge aclk);
    areset = 0;
    repeat (2) @(negedge aclk);

    // write then read back the same word
    send_n(3, SYNC, 32'h2000_0004, 32'hDEAD_BEEF);
    send_n(2, SYNC, 32'h1000_0004);
    wait_idle("wr_rd", 500);
    check_eq("wr_rd_resp_err", resp_err, 0);

    // read of untouched memory returns the default, exactly one push
    mem_default = 32'hFFFF_FFFF;
    p = n_push;
    send_n(2, SYNC, 32'h1000_0001);
    wait_idle("rd_default", 500);
    check_eq("rd_default_pushes", n_push - p, 1);

    // leading junk is discarded
    p = n_push;
    send_n(4, 32'h1234_5678, 32'h0, SYNC, 32'h1000_0000);
    wait_idle("junk", 500);
    check_eq("junk_pushes", n_push - p, 1);
    check_eq("junk_err_count", err_count, exp_errcnt);

    // bad opcode: counted, no response, then a normal read
    p = n_push;
    send_n(2, SYNC, 32'h7000_0000);
    wait_idle("badop", 500);
    check_eq("badop_err_count", err_count, exp_errcnt);
    check_eq("badop_busy", busy, 0);
    check_eq("badop_pushes", n_push - p, 0);
    send_n(2, SYNC, 32'h1000_0003);
    wait_idle("after_badop", 500);
    check_eq("after_badop_pushes", n_push - p, 1);

    // egress full back-pressure
    rsp_full = 1;
    p = n_push;
    send_n(2, SYNC, 32'h1000_0004);
    n = 0;
    while (dbg_state != 4'(RSP_PUSH) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check_eq("full_reach_push", n < 200, 1);
    repeat (8) @(negedge aclk);
    #2;
    check_eq("full_hold_state", dbg_state, 4'(RSP_PUSH));
    check_eq("full_no_push", n_push - p, 0);
    @(negedge aclk);
    rsp_full = 0;
    wait_idle("full_release", 500);
    check_eq("full_one_push", n_push - p, 1);

    // delayed wready, then a read that gets SLVERR
    w_delay_mode = 1;
    send_n(3, SYNC, 32'h2000_0008, 32'h1234_ABCD);
    wait_idle("wdelay", 500);
    w_delay_mode = 0;
    check_eq("wdelay_resp_err", resp_err, 0);
    send_n(2, SYNC, 32'h1800_0003);
    wait_idle("slverr", 500);
    check_eq("slverr_resp_err", resp_err, exp_err);
    send_n(2, SYNC, 32'h1000_0008);
    wait_idle("sticky", 500);
    check_eq("sticky_resp_err", resp_err, 1);
    pulse_reset();
    #2;
    check_eq("rst2_resp_err", resp_err, 0);
    check_eq("rst2_err_count", err_count, 0);

    // randomized frames with junk, gaps, error regions and egress back-pressure
    rand_full = 1;
    repeat (40) begin
      q.delete();
      repeat ($urandom_range(0, 2)) begin
        cmd = $urandom();
        if (cmd == SYNC) cmd = 32'h0;
        q.push_back(cmd);
      end
      q.push_back(SYNC);
      cmd = {4'h0, 28'($urandom_range(0, 63))};
      case ($urandom_range(0, 9))
        0: cmd = SYNC;
        1: cmd[31:28] = 4'h3 + 4'($urandom_range(0, 12));
        2, 3, 4, 5: begin
          cmd[31:28] = 4'h1;
          if ($urandom_range(0, 7) == 0) cmd[27] = 1'b1;
        end
        default: begin
          cmd[31:28] = 4'h2;
          if ($urandom_range(0, 7) == 0) cmd[27:26] = 2'b11;
        end
      endcase
      q.push_back(cmd);
      if (cmd[31:28] == 4'h2) q.push_back($urandom());
      send(q, 1'b1);
    end
    wait_idle("random", 20000);
    rand_full = 0;
    check_eq("random_resp_err", resp_err, exp_err);
    check_eq("random_err_count", err_count, exp_errcnt);

    // error counter saturation
    q.delete();
    repeat (260) begin
      q.push_back(SYNC);
      q.push_back(32'h3000_0000);
    end
    send(q, 1'b0);
    wait_idle("sat", 5000);
    check_eq("sat_err_count", err_count, exp_errcnt);
    check_eq("sat_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
